// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: encodings, state codes and the
// IF/ID slot record.
package fetch_stage_pkg;
  localparam int PC_W = 16;
  localparam logic [15:0] NOP_ENC  = 16'h0800;
  localparam logic [4:0]  HALT_OPC = 5'b00000;

  typedef logic [2:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH   = 3'd0;
  localparam fetch_state_t ST_WAIT    = 3'd1;
  localparam fetch_state_t ST_DISCARD = 3'd2;
  localparam fetch_state_t ST_HOLD    = 3'd3;
  localparam fetch_state_t ST_HALTED  = 3'd4;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc2;
    logic            valid;
    logic            halt;
    logic            err;
  } slot_t;

  function automatic logic is_halt(input logic [PC_W-1:0] instr);
    return instr[15:11] == HALT_OPC;
  endfunction
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect load beats sequential advance; otherwise holds.
import fetch_stage_pkg::*;

module fetch_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic            advance,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2
);
  assign pc_plus2 = pc + 16'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc <= RESET_PC;
    else if (load)    pc <= load_pc;
    else if (advance) pc <= pc_plus2;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the multi-cycle instruction memory and
// presents one registered slot per cycle to IF/ID.
//
// state      | meaning
// FETCH      | request imem at pc (suppressed while stall_in)
// WAIT       | request outstanding, waiting for imem_done
// DISCARD    | finishing a request made before a redirect; data dropped
// HOLD       | IF/ID stalled; slot frozen, optional captured word pending
// HALTED     | halt/error slot issued; idle until redirect
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic        imem_err,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2_out,
  output logic        valid_out,
  output logic        halt_out,
  output logic        err_out
);
  fetch_state_t    state;
  slot_t           slot, pend, cap;
  logic            pend_valid;
  logic [PC_W-1:0] pc, pc_plus2, discard_addr;
  logic            req_active, mem_done, capture, cap_halt;

  // A new request is never started while IF/ID is stalled, so nothing is ever
  // abandoned mid-access.
  assign req_active = (state == ST_WAIT) || (state == ST_DISCARD) ||
                      (state == ST_FETCH && !stall_in);
  assign imem_rd    = req_active && !rst;
  assign imem_addr  = (state == ST_DISCARD) ? discard_addr : pc;
  assign mem_done   = imem_done && !imem_stall;
  assign capture    = !redirect_valid && mem_done &&
                      ((state == ST_FETCH && !stall_in) || state == ST_WAIT);
  assign cap_halt   = imem_err || is_halt(imem_data);
  assign cap        = '{instr: imem_data, pc: pc, pc2: pc_plus2,
                        valid: 1'b1, halt: cap_halt, err: imem_err};

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect_valid),
    .load_pc  (redirect_pc),
    .advance  (capture && !imem_err),
    .pc       (pc),
    .pc_plus2 (pc_plus2)
  );

  function automatic slot_t bubble(input slot_t s);
    bubble       = s;
    bubble.instr = NOP_INSTR;
    bubble.valid = 1'b0;
    bubble.halt  = 1'b0;
    bubble.err   = 1'b0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_FETCH;
      slot         <= '{instr: NOP_INSTR, pc: RESET_PC, pc2: RESET_PC + 16'd2,
                        valid: 1'b0, halt: 1'b0, err: 1'b0};
      pend         <= '0;
      pend_valid   <= 1'b0;
      discard_addr <= RESET_PC;
    end else if (redirect_valid) begin
      slot         <= bubble(slot);
      pend_valid   <= 1'b0;
      discard_addr <= imem_addr;
      state        <= (req_active && !mem_done) ? ST_DISCARD : ST_FETCH;
    end else begin
      case (state)
        ST_FETCH, ST_WAIT: begin
          if (capture && stall_in) begin
            // word arrived while IF/ID is frozen: park it so release costs nothing
            pend       <= cap;
            pend_valid <= 1'b1;
            state      <= ST_HOLD;
          end else if (capture) begin
            slot  <= cap;
            state <= cap_halt ? ST_HALTED : ST_FETCH;
          end else begin
            if (!stall_in) slot <= bubble(slot);
            if (state == ST_FETCH) state <= stall_in ? ST_HOLD : ST_WAIT;
          end
        end
        ST_DISCARD: begin
          if (!stall_in) slot <= bubble(slot);
          if (mem_done) state <= ST_FETCH;
        end
        ST_HOLD: begin
          if (!stall_in) begin
            if (pend_valid) begin
              slot       <= pend;
              pend_valid <= 1'b0;
              state      <= pend.halt ? ST_HALTED : ST_FETCH;
            end else begin
              slot  <= bubble(slot);
              state <= slot.halt ? ST_HALTED : ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          if (!stall_in) slot <= bubble(slot);
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign instr_out    = slot.instr;
  assign pc_out       = slot.pc;
  assign pc_plus2_out = slot.pc2;
  assign valid_out    = slot.valid;
  assign halt_out     = slot.halt;
  assign err_out      = slot.err;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall_in, redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_data;
  logic        imem_rd, imem_stall, imem_done, imem_err;
  logic [15:0] instr_out, pc_out, pc_plus2_out;
  logic        valid_out, halt_out, err_out;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 0;
  int wait_cnt = 0;
  logic found;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .imem_stall(imem_stall), .imem_done(imem_done), .imem_err(imem_err),
    .instr_out(instr_out), .pc_out(pc_out), .pc_plus2_out(pc_plus2_out),
    .valid_out(valid_out), .halt_out(halt_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h4000;
      16'h0002: return 16'h4001;
      16'h0010: return 16'h0000;
      default:  return 16'h5000 | {4'h0, a[11:0]};
    endcase
  endfunction

  assign imem_done  = imem_rd && (wait_cnt >= lat);
  assign imem_stall = imem_rd && !imem_done;
  assign imem_data  = mem_word(imem_addr);
  assign imem_err   = imem_done && imem_addr[0];

  always @(posedge clk) begin
    if (!imem_rd || imem_done) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    step(); step();
    chk("rst_rd", imem_rd, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_instr", instr_out, 16'h0800);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_pc2", pc_plus2_out, 16'h0002);
    chk("rst_halt", halt_out, 0);
    chk("rst_err", err_out, 0);
    rst = 1'b0;
    #1;
    chk("first_rd", imem_rd, 1);
    chk("first_addr", imem_addr, 16'h0000);

    // single-cycle memory
    step();
    chk("s0_instr", instr_out, 16'h4000);
    chk("s0_pc", pc_out, 16'h0000);
    chk("s0_valid", valid_out, 1);
    step();
    chk("s1_instr", instr_out, 16'h4001);
    chk("s1_pc", pc_out, 16'h0002);
    chk("s1_pc2", pc_plus2_out, 16'h0004);
    chk("s1_valid", valid_out, 1);

    // three-cycle memory stall at 0x0004
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mst_valid", valid_out, 0);
      chk("mst_instr", instr_out, 16'h0800);
      chk("mst_addr", imem_addr, 16'h0004);
    end
    step();
    chk("mst_slot_pc", pc_out, 16'h0004);
    chk("mst_slot_instr", instr_out, 16'h5004);
    chk("mst_slot_valid", valid_out, 1);

    // redirect during WAIT
    step();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    chk("disc_valid", valid_out, 0);
    chk("disc_addr", imem_addr, 16'h0006);
    chk("disc_rd", imem_rd, 1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (valid_out) found = 1'b1;
    end
    chk("redir_found", found, 1);
    chk("redir_pc", pc_out, 16'h0100);
    chk("redir_pc2", pc_plus2_out, 16'h0102);
    chk("redir_instr", instr_out, 16'h5100);

    // halt at 0x0010, then resume via redirect to 0x0020
    lat = 0;
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect_valid = 1'b0;
    chk("squash_valid", valid_out, 0);
    step();
    chk("halt_flag", halt_out, 1);
    chk("halt_valid", valid_out, 1);
    chk("halt_pc", pc_out, 16'h0010);
    chk("halted_rd", imem_rd, 0);
    step();
    chk("halted_bubble_halt", halt_out, 0);
    chk("halted_bubble_valid", valid_out, 0);
    chk("halted_rd2", imem_rd, 0);
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect_valid = 1'b0;
    chk("resume_addr", imem_addr, 16'h0020);
    chk("resume_rd", imem_rd, 1);
    step();
    chk("resume_pc", pc_out, 16'h0020);
    chk("resume_instr", instr_out, 16'h5020);

    // hazard stall with valid slot at 0x0008
    redirect_valid = 1'b1; redirect_pc = 16'h0008;
    step();
    redirect_valid = 1'b0;
    step();
    chk("hz_pc", pc_out, 16'h0008);
    stall_in = 1'b1;
    #1;
    chk("hz_rd_off", imem_rd, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hz_frozen_pc", pc_out, 16'h0008);
      chk("hz_frozen_valid", valid_out, 1);
      chk("hz_rd", imem_rd, 0);
    end
    stall_in = 1'b0;
    step();
    chk("hz_release_bubble", valid_out, 0);
    step();
    chk("hz_next_pc", pc_out, 16'h000A);
    chk("hz_next_valid", valid_out, 1);

    // word captured during a stall is released without an extra cycle
    lat = 1;
    step();
    stall_in = 1'b1;
    step();
    chk("pend_frozen_valid", valid_out, 0);
    chk("pend_rd", imem_rd, 0);
    stall_in = 1'b0;
    step();
    chk("pend_pc", pc_out, 16'h000C);
    chk("pend_instr", instr_out, 16'h500C);
    chk("pend_valid", valid_out, 1);

    // misaligned fetch, then reset while stalled
    lat = 0;
    redirect_valid = 1'b1; redirect_pc = 16'h0001;
    step();
    redirect_valid = 1'b0;
    step();
    chk("err_err", err_out, 1);
    chk("err_halt", halt_out, 1);
    chk("err_valid", valid_out, 1);
    chk("err_pc", pc_out, 16'h0001);
    chk("err_rd", imem_rd, 0);
    stall_in = 1'b1;
    step();
    chk("err_frozen", err_out, 1);
    rst = 1'b1;
    #1;
    chk("rst_stall_pc", pc_out, 16'h0000);
    chk("rst_stall_valid", valid_out, 0);
    chk("rst_stall_err", err_out, 0);
    stall_in = 1'b0;
    step();
    rst = 1'b0;

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc", pc_out, 16'hFFFE);
    chk("wrap_pc2", pc_plus2_out, 16'h0000);
    chk("wrap_instr", instr_out, 16'h5FFE);
    step();
    chk("wrap_next_pc", pc_out, 16'h0000);
    chk("wrap_next_instr", instr_out, 16'h4000);

    // reset during WAIT
    lat = 3;
    step();
    chk("rw_rd", imem_rd, 1);
    rst = 1'b1;
    #1;
    chk("rw_rd_rst", imem_rd, 0);
    chk("rw_pc", pc_out, 16'h0000);
    step();
    rst = 1'b0;
    lat = 0;
    step();
    chk("rw_after_pc", pc_out, 16'h0000);
    chk("rw_after_instr", instr_out, 16'h4000);
    chk("rw_after_valid", valid_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
